mdu_scheduler: RTL and testbench

Multi-cycle multiply/divide scheduler for the five-stage MIPS pipeline. Accepts mult/multu/div/divu/mthi/mtlo from the E stage, holds the HI/LO registers, runs a countdown busy sequence per operation, and raises the stall the hazard unit uses to freeze F/D when a D-stage instruction needs the unit while it is occupied. It owns HI/LO; mfhi/mflo read them through `rd_data`.

---
 rtl/mdu_scheduler.sv | 153 +++++++++++++++
 tb/tb_mdu_scheduler.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/mdu_scheduler.sv
// Multi-cycle multiply/divide scheduler owning HI/LO, with countdown busy sequencing and D-stage stall.
// Optional macro MDU_DIV_ZERO_SKIP_EN: divide-by-zero finishes in one busy cycle and leaves HI/LO unchanged.
module mdu_scheduler #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  e_op,
    input  logic [31:0] e_src_a,
    input  logic [31:0] e_src_b,
    input  logic        e_rd_hi,
    input  logic        d_uses_md,
    output logic        busy,
    output logic        md_stall,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] rd_data
);

    typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

    localparam logic [3:0] MULT_CNT = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_CNT  = 4'(DIV_CYCLES);

    state_t      state;
    logic [3:0]  cnt;
    logic [31:0] hiReg;
    logic [31:0] loReg;
    logic [31:0] opA;
    logic [31:0] opB;
    logic        opSigned;
`ifdef MDU_DIV_ZERO_SKIP_EN
    logic        divSkip;
`endif

    logic        isStart;
    logic        negA;
    logic        negB;
    logic [63:0] extA;
    logic [63:0] extB;
    logic [63:0] product;
    logic [31:0] magA;
    logic [31:0] magB;
    logic [31:0] magQ;
    logic [31:0] magR;
    logic [31:0] quotient;
    logic [31:0] remainder;

    // Signed divide is done on magnitudes so 0x80000000 / -1 wraps cleanly instead of overflowing.
    always_comb begin
        negA      = opSigned & opA[31];
        negB      = opSigned & opB[31];
        extA      = {{32{negA}}, opA};
        extB      = {{32{negB}}, opB};
        product   = extA * extB;
        magA      = negA ? (~opA + 32'd1) : opA;
        magB      = negB ? (~opB + 32'd1) : opB;
        magQ      = '0;
        magR      = '0;
        if (magB != 32'd0) begin
            magQ = magA / magB;
            magR = magA % magB;
        end
        quotient  = (negA ^ negB) ? (~magQ + 32'd1) : magQ;
        remainder = negA ? (~magR + 32'd1) : magR;
        if (opB == 32'd0) begin
            quotient  = 32'hFFFF_FFFF;
            remainder = opA;
        end
    end

    assign isStart  = (e_op >= 3'd1) && (e_op <= 3'd4);
    assign busy     = (state != IDLE);
    assign md_stall = d_uses_md & (busy | isStart);
    assign hi       = hiReg;
    assign lo       = loReg;
    assign rd_data  = e_rd_hi ? hiReg : loReg;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            hiReg    <= '0;
            loReg    <= '0;
            opA      <= '0;
            opB      <= '0;
            opSigned <= 1'b0;
`ifdef MDU_DIV_ZERO_SKIP_EN
            divSkip  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    case (e_op)
                        3'd1, 3'd2: begin
                            opA      <= e_src_a;
                            opB      <= e_src_b;
                            opSigned <= (e_op == 3'd1);
                            cnt      <= MULT_CNT;
                            state    <= MUL;
                        end
                        3'd3, 3'd4: begin
                            opA      <= e_src_a;
                            opB      <= e_src_b;
                            opSigned <= (e_op == 3'd3);
`ifdef MDU_DIV_ZERO_SKIP_EN
                            if (e_src_b == 32'd0) begin
                                cnt     <= 4'd1;
                                divSkip <= 1'b1;
                            end else begin
                                cnt     <= DIV_CNT;
                                divSkip <= 1'b0;
                            end
`else
                            cnt      <= DIV_CNT;
`endif
                            state    <= DIV;
                        end
                        3'd5:    hiReg <= e_src_a;
                        3'd6:    loReg <= e_src_a;
                        default: ;
                    endcase
                end
                MUL: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        hiReg <= product[63:32];
                        loReg <= product[31:0];
                        state <= IDLE;
                    end
                end
                DIV: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
`ifdef MDU_DIV_ZERO_SKIP_EN
                        if (!divSkip) begin
                            hiReg <= remainder;
                            loReg <= quotient;
                        end
`else
                        hiReg <= remainder;
                        loReg <= quotient;
`endif
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_scheduler.sv
// Directed, table-driven bench for mdu_scheduler: latency, HI/LO results, stall, back-to-back, reset abort.
module tb_mdu_scheduler;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  e_op;
    logic [31:0] e_src_a;
    logic [31:0] e_src_b;
    logic        e_rd_hi;
    logic        d_uses_md;
    logic        busy;
    logic        md_stall;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] rd_data;

    int compared = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    mdu_scheduler #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .e_op(e_op), .e_src_a(e_src_a), .e_src_b(e_src_b),
        .e_rd_hi(e_rd_hi), .d_uses_md(d_uses_md), .busy(busy), .md_stall(md_stall),
        .hi(hi), .lo(lo), .rd_data(rd_data)
    );

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] expHi;
        logic [31:0] expLo;
        int          expCycles;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one op with mfhi/mflo in D, then count busy cycles with a bounded wait.
    task automatic runOp(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         output int cycles, output int stallMiss);
        logic expStart;
        expStart  = (op >= 3'd1) && (op <= 3'd4);
        e_op      = op;
        e_src_a   = a;
        e_src_b   = b;
        d_uses_md = 1'b1;
        #1;
        chk("start_stall", {31'd0, md_stall}, {31'd0, expStart});
        step();
        e_op      = 3'd0;
        cycles    = 0;
        stallMiss = 0;
        #1;
        while (busy === 1'b1 && cycles < 40) begin
            if (md_stall !== 1'b1) stallMiss++;
            cycles++;
            step();
        end
    endtask

    initial begin
        int cycles;
        int stallMiss;
        int lateWrite;

        vecs[0] = '{3'd1, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 5};
        vecs[1] = '{3'd2, 32'hFFFF_FFFE, 32'd3, 32'h0000_0002, 32'hFFFF_FFFA, 5};
        vecs[2] = '{3'd3, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10};
        vecs[3] = '{3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 10};
        vecs[4] = '{3'd4, 32'hFFFF_FFF9, 32'd2, 32'h0000_0001, 32'h7FFF_FFFC, 10};
        vecs[5] = '{3'd1, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000, 5};
        vecs[6] = '{3'd3, 32'd7, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 10};
        vecs[7] = '{3'd5, 32'h1234_5678, 32'd0, 32'h1234_5678, 32'hFFFF_FFFD, 0};
        vecs[8] = '{3'd6, 32'hCAFE_F00D, 32'd0, 32'h1234_5678, 32'hCAFE_F00D, 0};
`ifdef MDU_DIV_ZERO_SKIP_EN
        vecs[9] = '{3'd3, 32'd5, 32'd0, 32'h1234_5678, 32'hCAFE_F00D, 1};
`else
        vecs[9] = '{3'd3, 32'd5, 32'd0, 32'h0000_0005, 32'hFFFF_FFFF, 10};
`endif

        reset = 1'b1; e_op = 3'd0; e_src_a = '0; e_src_b = '0; e_rd_hi = 1'b0; d_uses_md = 1'b1;
        step(); step();
        reset = 1'b0;
        #1;
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_hi", hi, 32'd0);
        chk("reset_lo", lo, 32'd0);
        chk("reset_stall", {31'd0, md_stall}, 32'd0);
        $display("reset: busy=%0d hi=%h lo=%h", busy, hi, lo);

        for (int i = 0; i < 10; i++) begin
            runOp(vecs[i].op, vecs[i].a, vecs[i].b, cycles, stallMiss);
            chk($sformatf("v%0d_cycles", i), 32'(cycles), 32'(vecs[i].expCycles));
            chk($sformatf("v%0d_busy_stall", i), 32'(stallMiss), 32'd0);
            chk($sformatf("v%0d_hi", i), hi, vecs[i].expHi);
            chk($sformatf("v%0d_lo", i), lo, vecs[i].expLo);
            chk($sformatf("v%0d_stall_after", i), {31'd0, md_stall}, 32'd0);
            e_rd_hi = 1'b1;
            #1;
            chk($sformatf("v%0d_rd_hi", i), rd_data, vecs[i].expHi);
            e_rd_hi = 1'b0;
            #1;
            chk($sformatf("v%0d_rd_lo", i), rd_data, vecs[i].expLo);
            $display("vec %0d: op=%0d a=%h b=%h busy_cycles=%0d hi=%h lo=%h", i, vecs[i].op,
                     vecs[i].a, vecs[i].b, cycles, hi, lo);
        end

        // Back-to-back: second start lands in the cycle busy falls.
        runOp(3'd1, 32'd2, 32'd3, cycles, stallMiss);
        chk("b2b_first_lo", lo, 32'd6);
        e_op = 3'd2; e_src_a = 32'd4; e_src_b = 32'd5;
        step();
        e_op = 3'd0;
        #1;
        chk("b2b_accepted", {31'd0, busy}, 32'd1);
        cycles = 1;
        while (busy === 1'b1 && cycles < 40) begin
            cycles++;
            step();
        end
        chk("b2b_cycles", 32'(cycles - 1), 32'd5);
        chk("b2b_lo", lo, 32'd20);
        chk("b2b_hi", hi, 32'd0);
        $display("back-to-back: mult 2*3 then multu 4*5 lo=%h", lo);

        // Reset in the third busy cycle of a divide aborts it.
        e_op = 3'd3; e_src_a = 32'd100; e_src_b = 32'd7;
        step();
        e_op = 3'd0;
        step(); step();
        chk("abort_busy_c3", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        #1;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_hi", hi, 32'd0);
        chk("abort_lo", lo, 32'd0);
        lateWrite = 0;
        for (int k = 0; k < 12; k++) begin
            step();
            if (hi !== 32'd0 || lo !== 32'd0 || busy !== 1'b0) lateWrite++;
        end
        chk("abort_no_late_write", 32'(lateWrite), 32'd0);
        $display("reset abort: busy=%0d hi=%h lo=%h", busy, hi, lo);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
